// File: rtl/nibble_serial_sub_ctrl_if.sv
// Operand/result handshake bundle for the nibble-serial subtractor.
// Producer drives start_valid/a/b/bin, consumer drives res_ready; the block answers on the rest.
interface nibble_serial_sub_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             zero;
    logic             busy;

    modport slave (
        input  start_valid, a, b, bin, res_ready,
        output start_ready, res_valid, d, bout, zero, busy
    );

    modport master (
        output start_valid, a, b, bin, res_ready,
        input  start_ready, res_valid, d, bout, zero, busy
    );
endinterface

// File: rtl/nibble_serial_sub_ctrl.sv
// Purpose: WIDTH-bit a - b - bin computed one 4-bit borrow-ripple nibble per clock, LSB first.
// Latency: res_valid rises WIDTH/4 edges after the accept edge; one operation in flight at a time.
// Backpressure: result held in DONE while res_ready is low; start_ready only high in IDLE.

module nsub_fs_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);
    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
endmodule

module nibble_serial_sub_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    nibble_serial_sub_ctrl_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = $clog2(NIB);
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] d_sh_q, d_sh_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [3:0]       st_diff;
    logic [4:0]       st_chain;
    logic [WIDTH-1:0] d_next;

    // 4-bit ripple stage; the registered borrow feeds bit 0 and links nibbles.
    assign st_chain[0] = brw_q;
    for (genvar i = 0; i < 4; i++) begin : g_fs
        nsub_fs_cell u_fs (
            .a_i    (a_sh_q[i]),
            .b_i    (b_sh_q[i]),
            .bin_i  (st_chain[i]),
            .d_o    (st_diff[i]),
            .bout_o (st_chain[i+1])
        );
    end

    assign d_next = {st_diff, d_sh_q[WIDTH-1:4]};

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        d_sh_d  = d_sh_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_valid) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    brw_d   = bus.bin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d = a_sh_q >> 4;
                b_sh_d = b_sh_q >> 4;
                d_sh_d = d_next;
                brw_d  = st_chain[4];
                if (cnt_q == LAST) begin
                    // Counter parks on the last nibble rather than wrapping.
                    bout_d  = st_chain[4];
                    zero_d  = (d_next == '0);
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            d_sh_q  <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            d_sh_q  <= d_sh_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.start_ready = (state_q == ST_IDLE);
    assign bus.res_valid   = (state_q == ST_DONE);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.d           = d_sh_q;
    assign bus.bout        = bout_q;
    assign bus.zero        = zero_q;
endmodule

// File: tb/tb_nibble_serial_sub_ctrl.sv
// Scoreboard bench for nibble_serial_sub_ctrl at WIDTH=16 and WIDTH=32.
// Drivers push expected results on accept; a negedge monitor pops and compares on res_valid.
module tb_nibble_serial_sub_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_sub_ctrl_if #(.WIDTH(16)) if16();
    nibble_serial_sub_ctrl_if #(.WIDTH(32)) if32();

    nibble_serial_sub_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
    nibble_serial_sub_ctrl #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));

    typedef struct {
        logic [31:0] d;
        logic        bout;
        logic        zero;
        int          acc;
    } exp_t;

    exp_t        q16[$];
    exp_t        q32[$];
    int          n_chk = 0;
    int          n_fail = 0;
    bit          got[2];
    logic [31:0] cap_d[2];
    logic        cap_b[2];
    logic        cap_z[2];
    int          hs_cyc[2];
    bit          rr_rand[2];
    logic        rr_val[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic sr(input int k);
        return (k == 0) ? if16.start_ready : if32.start_ready;
    endfunction

    function automatic int qsz(input int k);
        return (k == 0) ? q16.size() : q32.size();
    endfunction

    function automatic void model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                  input logic bi, output logic [31:0] ed, output logic eb,
                                  output logic ez);
        longint unsigned mask, aa, bb, df;
        mask = (64'd1 << w) - 1;
        aa   = {32'd0, av} & mask;
        bb   = {32'd0, bv} & mask;
        df   = (aa - bb - {63'd0, bi}) & mask;
        ed   = df[31:0];
        eb   = (aa < bb + {63'd0, bi});
        ez   = (df == 0);
    endfunction

    // Consumer side: res_ready is either a fixed level or randomly stalled.
    initial begin
        if16.res_ready = 1'b1;
        if32.res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if16.res_ready = rr_rand[0] ? ($urandom_range(0, 3) != 0) : rr_val[0];
            if32.res_ready = rr_rand[1] ? ($urandom_range(0, 3) != 0) : rr_val[1];
        end
    end

    task automatic mon_step(input int k, input logic rstn, input logic rv, input logic rr,
                            input logic [31:0] dv, input logic bo, input logic zo);
        exp_t e;
        if (!rstn) begin
            got[k] = 1'b0;
            return;
        end
        if (!rv) return;
        if (!got[k]) begin
            if (qsz(k) == 0) begin
                chk($sformatf("unexpected_result%0d", k), 32'd1, 32'd0);
                return;
            end
            if (k == 0) e = q16.pop_front();
            else        e = q32.pop_front();
            chk($sformatf("d%0d", k), dv, e.d);
            chk($sformatf("bout%0d", k), {31'd0, bo}, {31'd0, e.bout});
            chk($sformatf("zero%0d", k), {31'd0, zo}, {31'd0, e.zero});
            chk($sformatf("latency%0d", k), cyc - e.acc, (k == 0) ? 4 : 8);
            got[k]   = 1'b1;
            cap_d[k] = dv;
            cap_b[k] = bo;
            cap_z[k] = zo;
        end else begin
            chk($sformatf("hold_d%0d", k), dv, cap_d[k]);
            chk($sformatf("hold_bz%0d", k), {30'd0, bo, zo}, {30'd0, cap_b[k], cap_z[k]});
        end
        if (rr) begin
            got[k]    = 1'b0;
            hs_cyc[k] = cyc;
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, rst_n, if16.res_valid, if16.res_ready, {16'd0, if16.d}, if16.bout, if16.zero);
        mon_step(1, rst_n, if32.res_valid, if32.res_ready, if32.d, if32.bout, if32.zero);
    end

    task automatic do_op(input int k, input logic [31:0] av, input logic [31:0] bv,
                         input logic bi, input logic [31:0] ed, input logic eb,
                         input logic ez, output int acc);
        exp_t e;
        int   w;
        acc = -1;
        @(posedge clk);
        #1;
        if (k == 0) begin
            if16.start_valid = 1'b1; if16.a = av[15:0]; if16.b = bv[15:0]; if16.bin = bi;
        end else begin
            if32.start_valid = 1'b1; if32.a = av; if32.b = bv; if32.bin = bi;
        end
        @(negedge clk);
        w = 0;
        while (!sr(k) && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!sr(k)) begin
            chk($sformatf("accept_timeout%0d", k), 32'd0, 32'd1);
            if (k == 0) if16.start_valid = 1'b0;
            else        if32.start_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc    = cyc;
        e.d    = ed;
        e.bout = eb;
        e.zero = ez;
        e.acc  = cyc;
        if (k == 0) begin
            q16.push_back(e);
            if16.start_valid = 1'b0;
        end else begin
            q32.push_back(e);
            if32.start_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input int k);
        int w = 0;
        while ((qsz(k) != 0 || !sr(k)) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (qsz(k) != 0 || !sr(k)) chk($sformatf("drain_timeout%0d", k), 32'd0, 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc, w;
        bit          seen;
        logic [31:0] ra, rb, ed;
        logic        rbi, eb, ez;

        if16.start_valid = 1'b0; if16.a = '0; if16.b = '0; if16.bin = 1'b0;
        if32.start_valid = 1'b0; if32.a = '0; if32.b = '0; if32.bin = 1'b0;
        rr_rand[0] = 1'b0; rr_rand[1] = 1'b0;
        rr_val[0]  = 1'b1; rr_val[1]  = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_d", {16'd0, if16.d}, 32'd0);
        chk("rst_flags", {27'd0, if16.bout, if16.zero, if16.res_valid, if16.busy, if16.start_ready},
            32'b00001);
        chk("rst32_flags", {31'd0, if32.start_ready}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vectors, hand-computed.
        do_op(0, 32'h1234, 32'h0235, 1'b0, 32'h0FFF, 1'b0, 1'b0, acc);
        do_op(0, 32'h0000, 32'h0001, 1'b0, 32'hFFFF, 1'b1, 1'b0, acc);
        do_op(0, 32'h5A5A, 32'h5A59, 1'b1, 32'h0000, 1'b0, 1'b1, acc);
        do_op(0, 32'hFFFF, 32'hFFFF, 1'b1, 32'hFFFF, 1'b1, 1'b0, acc);
        do_op(1, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, acc);
        wait_drain(0);
        wait_drain(1);

        // Backpressure: result held with a pending start request toggling operands.
        rr_val[0] = 1'b0;
        do_op(0, 32'h00FF, 32'h0F0F, 1'b0, 32'hF1F0, 1'b1, 1'b0, acc);
        w = 0;
        while (!if16.res_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("bp_res_valid_seen", {31'd0, if16.res_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if16.start_valid = 1'b1;
            if16.a = 16'($urandom);
            if16.b = 16'($urandom);
            if16.bin = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("bp_start_ready", {31'd0, if16.start_ready}, 32'd0);
            chk("bp_res_valid", {31'd0, if16.res_valid}, 32'd1);
        end
        rr_val[0] = 1'b1;
        do_op(0, 32'hA000, 32'h0001, 1'b1, 32'h9FFE, 1'b0, 1'b0, acc);
        chk("bp_accept_next_cycle", acc, hs_cyc[0] + 2);
        wait_drain(0);

        // Asynchronous reset mid-RUN discards the operation.
        do_op(0, 32'h1234, 32'h0235, 1'b0, 32'h0FFF, 1'b0, 1'b0, acc);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_d", {16'd0, if16.d}, 32'd0);
        chk("arst_flags", {27'd0, if16.bout, if16.zero, if16.res_valid, if16.busy, if16.start_ready},
            32'b00001);
        q16.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (if16.res_valid) seen = 1'b1;
        end
        chk("no_result_after_rst", {31'd0, seen}, 32'd0);
        do_op(0, 32'h8000, 32'h0001, 1'b0, 32'h7FFF, 1'b0, 1'b0, acc);
        wait_drain(0);

        // Random regression with stalls on both widths.
        rr_rand[0] = 1'b1;
        rr_rand[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 1000; i++) begin
                ra  = $urandom;
                rb  = $urandom;
                rbi = 1'($urandom_range(0, 1));
                if (i % 50 == 0) rb = ra;
                model((k == 0) ? 16 : 32, ra, rb, rbi, ed, eb, ez);
                do_op(k, ra, rb, rbi, ed, eb, ez, acc);
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end
            wait_drain(k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/nibble_serial_sub_ctrl.md
Name: nibble_serial_sub_ctrl

Overview:
Sequencer that computes a WIDTH-bit subtraction by running a 4-bit borrow-ripple subtract stage over the operands, one nibble per clock, LSB nibble first.
The stage is built from the team's full-subtractor cells.
A registered borrow links successive nibbles.
The block sits between an operand producer and a result consumer, with valid/ready handshakes on both sides, and provides a wide subtract at 4-bit datapath cost.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 8.
NIB, WIDTH/4 (derived, localparam), number of nibble passes per operation.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
start_valid  in  1  operand request valid.
start_ready  out  1  block can accept operands; high only in IDLE.
a  in  WIDTH  minuend, sampled on accept.
b  in  WIDTH  subtrahend, sampled on accept.
bin  in  1  initial borrow-in, sampled on accept.
res_valid  out  1  result available; high only in DONE.
res_ready  in  1  consumer accepts result.
d  out  WIDTH  difference, a - b - bin mod 2^WIDTH.
bout  out  1  final borrow-out; 1 iff a < b + bin (unsigned).
zero  out  1  1 iff d == 0; valid while res_valid.
busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - d = 0, bout = 0, zero = 0, res_valid = 0, busy = 0, start_ready = 1.
  - Operand shift registers, borrow register and nibble counter cleared.
- Reset asserted mid-RUN or mid-DONE:
  - The operation is discarded and no result is ever presented.
  - After rst_n deasserts, the block is in IDLE.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - start_ready = 1.
  - Accept occurs when start_valid && start_ready at a rising edge.
  - On accept: load a_sh <= a, b_sh <= b, brw <= bin, cnt <= 0, next state RUN.
  - Without start_valid, remain in IDLE; d and bout hold their last values.
- RUN (one nibble per cycle):
  - Stage inputs: a_sh[3:0], b_sh[3:0], brw.
  - Stage outputs: 4-bit diff and a borrow computed by ripple through 4 bit cells.
  - Each cycle:
    - d_sh <= {diff, d_sh[WIDTH-1:4]}.
    - a_sh >>= 4, b_sh >>= 4.
    - brw <= stage borrow.
    - cnt <= cnt + 1.
  - When cnt == NIB-1: next state DONE; bout <= stage borrow; zero <= (final d_sh value == 0).
  - start_valid is ignored in RUN; start_ready = 0.
- DONE:
  - res_valid = 1.
  - d, bout and zero stay stable until the handshake completes.
  - On res_valid && res_ready: next state IDLE.
  - res_ready low holds DONE indefinitely (backpressure) with outputs unchanged.
- Timing:
  - Latency: res_valid rises exactly NIB rising edges after the accept edge (4 for WIDTH=16).
  - No overlap between operations: a new accept is possible at the earliest one cycle after the result handshake.
  - Minimum period is NIB+2 cycles per operation.
- Simultaneous events: a result handshake and start_valid in the same cycle do not produce an accept, because start_ready is 0 in DONE. The start is taken on the next cycle in IDLE.
- Counter: width is clog2(NIB). It never wraps past NIB-1 and is cleared on accept.
- Arithmetic: unsigned two's-complement wrap.
  - The result must equal (a - b - bin) mod 2^WIDTH bit-exactly.
  - The borrow chain must pass through all nibbles, including the MSB nibble.
- Outputs are registered and free of combinational paths from inputs, except start_ready and res_valid, which are decoded from state only.

Test Plan:
- WIDTH=16: accept a=0x1234, b=0x0235, bin=0 -> d=0x0FFF, bout=0, zero=0; res_valid high exactly 4 cycles after the accept edge.
- a=0x0000, b=0x0001, bin=0 -> d=0xFFFF, bout=1. This exercises borrow ripple through every nibble.
- a=0x5A5A, b=0x5A59, bin=1 -> d=0x0000, zero=1, bout=0. Then a=0xFFFF, b=0xFFFF, bin=1 -> d=0xFFFF, bout=1.
- Backpressure: hold res_ready=0 for 5 cycles in DONE, with start_valid=1 and new operands toggling.
  - Required: d, bout and res_valid stay stable; start_ready stays 0.
  - After res_ready=1, the block returns to IDLE and accepts the pending operands the following cycle.
- Assert rst_n=0 asynchronously after the 2nd RUN cycle (between edges) -> all outputs zero immediately and start_ready=1; no res_valid follows. The next operation 0x8000-0x0001 -> d=0x7FFF, bout=0.
- Random regression: 1000 random a/b/bin pairs at WIDTH=16 and WIDTH=32, with random handshake stalls. Compare each result against a reference model; latency must equal NIB every time.
